// File: rtl/ball_engine.sv
// Breakout-style ball engine: serves the ball from the paddle and advances
// it one physics step per accepted frame tick. It bounces off the walls,
// scans the brick grid one brick per cycle, and handles paddle bounces,
// lost balls, game over and win.
module ball_engine #(
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int BALL_SIZE  = 7,
   parameter int BRICK_ROWS = 5,
   parameter int BRICK_COLS = 5,
   parameter int BRICK_X0   = 40,
   parameter int BRICK_Y0   = 40,
   parameter int BRICK_W    = 80,
   parameter int BRICK_H    = 30,
   parameter int PITCH_X    = 120,
   parameter int PITCH_Y    = 50,
   parameter int PADDLE_Y   = 440,
   parameter int PADDLE_W   = 100,
   parameter int PADDLE_H   = 10,
   parameter int SPEED      = 4,
   parameter int LIVES      = 3
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 frame_tick,
   input  logic                                 launch,
   input  logic [9:0]                           paddle_x,
   output logic [9:0]                           x_out,
   output logic [9:0]                           y_out,
   output logic                                 erase_enable,
   output logic [5:0]                           e_pos,
   output logic [BRICK_ROWS*BRICK_COLS-1:0]     active_mask,
   output logic [15:0]                          score,
   output logic [2:0]                           lives,
   output logic                                 game_over,
   output logic                                 win,
   output logic                                 busy,
   output logic                                 tick_overrun
);

   localparam int N = BRICK_ROWS * BRICK_COLS;
   localparam logic [9:0]         X_MAX    = 10'(SCREEN_W - BALL_SIZE);
   localparam logic signed [10:0] X_MAX_S  = $signed({1'b0, X_MAX});
   localparam logic [9:0]         Y_LOST   = 10'(SCREEN_H - BALL_SIZE);
   localparam logic [9:0]         SERVE_Y  = 10'(PADDLE_Y - BALL_SIZE - 1);
   localparam logic signed [10:0] SPD      = 11'(SPEED);
   localparam logic [5:0]         LAST_IDX = 6'(N - 1);
   localparam logic [5:0]         LAST_COL = 6'(BRICK_COLS - 1);

   typedef enum logic [2:0] {
      ST_SERVE, ST_IDLE, ST_STEP, ST_SCAN, ST_PADDLE, ST_LOST, ST_OVER, ST_WIN
   } state_t;

   state_t                state_q, state_d;
   logic [9:0]            x_q, x_d, y_q, y_d, cx_q, cx_d;
   logic signed [10:0]    dx_q, dx_d, dy_q, dy_d;
   logic [5:0]            idx_q, idx_d, row_q, row_d, col_q, col_d;
   logic [N-1:0]          mask_q, mask_d;
   logic [15:0]           score_q, score_d;
   logic [2:0]            lives_q, lives_d;
   logic                  erase_q, erase_d, ovr_q, ovr_d;
   logic [5:0]            epos_q, epos_d;

   // score counter that sticks at full scale instead of wrapping
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic                  busy_w;
   logic signed [10:0]    nx, ny;
   logic [15:0]           bl, br, bt, bb, bx, by, pl, ctr, cxw;
   logic [9:0]            trk;
   logic [N-1:0]          sel;
   logic                  brick_hit, cx_in, paddle_hit, in_left, in_right;

   assign busy_w = (state_q == ST_STEP) || (state_q == ST_SCAN) || (state_q == ST_PADDLE);

   // candidate position after adding the velocity; wall handling decides what sticks
   assign nx = $signed({1'b0, x_q}) + dx_q;
   assign ny = $signed({1'b0, y_q}) + dy_q;

   // ball box and current brick box, widened so the edge sums cannot overflow
   assign bl  = {6'd0, x_q};
   assign br  = bl + 16'(BALL_SIZE);
   assign bt  = {6'd0, y_q};
   assign bb  = bt + 16'(BALL_SIZE);
   assign bx  = 16'(BRICK_X0) + 16'(col_q) * 16'(PITCH_X);
   assign by  = 16'(BRICK_Y0) + 16'(row_q) * 16'(PITCH_Y);
   assign sel = N'(1) << idx_q;
   assign cxw = {6'd0, cx_q};

   assign brick_hit = (|(mask_q & sel)) && (bl < bx + 16'(BRICK_W)) && (br > bx) &&
                      (bt < by + 16'(BRICK_H)) && (bb > by);
   // pre-step centre inside the brick's columns means the ball came in through top/bottom
   assign cx_in     = (cxw >= bx) && (cxw < bx + 16'(BRICK_W));

   assign pl  = {6'd0, paddle_x};
   assign trk = 10'(pl + 16'(PADDLE_W / 2) - 16'(BALL_SIZE / 2));
   assign ctr = bl + 16'(BALL_SIZE / 2);
   assign paddle_hit = (dy_q > 11'sd0) && (bb >= 16'(PADDLE_Y)) &&
                       (bt < 16'(PADDLE_Y + PADDLE_H)) &&
                       (bl < pl + 16'(PADDLE_W)) && (br > pl);
   assign in_left  = ctr < pl + 16'(PADDLE_W / 3);
   assign in_right = ctr >= pl + 16'(2 * PADDLE_W / 3);

   // state and datapath registers; reset drops straight back to a fresh serve
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_SERVE;
         x_q     <= '0;
         y_q     <= '0;
         cx_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         idx_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
         mask_q  <= '1;
         score_q <= '0;
         lives_q <= 3'(LIVES);
         erase_q <= 1'b0;
         epos_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cx_q    <= cx_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         idx_q   <= idx_d;
         row_q   <= row_d;
         col_q   <= col_d;
         mask_q  <= mask_d;
         score_q <= score_d;
         lives_q <= lives_d;
         erase_q <= erase_d;
         epos_q  <= epos_d;
         ovr_q   <= ovr_d;
      end
   end

   // next-state and datapath updates for every game phase
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      cx_d    = cx_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      idx_d   = idx_q;
      row_d   = row_q;
      col_d   = col_q;
      mask_d  = mask_q;
      score_d = score_q;
      lives_d = lives_q;
      erase_d = 1'b0;
      epos_d  = epos_q;
      ovr_d   = ovr_q | (frame_tick & busy_w);

      case (state_q)
         ST_SERVE: begin
            x_d = trk;
            y_d = SERVE_Y;
            if (launch) begin
               dx_d    = -SPD;
               dy_d    = -SPD;
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (frame_tick) begin
               cx_d    = x_q + 10'(BALL_SIZE / 2);
               state_d = ST_STEP;
            end
         end
         ST_STEP: begin
            if (nx < 11'sd0) begin
               x_d  = '0;
               dx_d = -dx_q;
            end else if (nx > X_MAX_S) begin
               x_d  = X_MAX;
               dx_d = -dx_q;
            end else begin
               x_d = nx[9:0];
            end
            if (ny < 11'sd0) begin
               y_d  = '0;
               dy_d = -dy_q;
            end else begin
               y_d = ny[9:0];
            end
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = ST_SCAN;
         end
         ST_SCAN: begin
            if (brick_hit) begin
               mask_d  = mask_q & ~sel;
               erase_d = 1'b1;
               epos_d  = idx_q;
               score_d = sat_inc(score_q);
               if (cx_in) dy_d = -dy_q;
               else       dx_d = -dx_q;
               state_d = ST_PADDLE;
            end else if (idx_q == LAST_IDX) begin
               state_d = ST_PADDLE;
            end else begin
               idx_d = idx_q + 6'd1;
               if (col_q == LAST_COL) begin
                  col_d = '0;
                  row_d = row_q + 6'd1;
               end else begin
                  col_d = col_q + 6'd1;
               end
            end
         end
         ST_PADDLE: begin
            if (paddle_hit) begin
               dy_d = -SPD;
               if (in_left)       dx_d = -SPD;
               else if (in_right) dx_d = SPD;
            end
            if (y_q >= Y_LOST)        state_d = ST_LOST;
            else if (mask_q == '0)    state_d = ST_WIN;
            else                      state_d = ST_IDLE;
         end
         ST_LOST: begin
            lives_d = lives_q - 3'd1;
            dx_d    = '0;
            dy_d    = '0;
            state_d = (lives_q <= 3'd1) ? ST_OVER : ST_SERVE;
         end
         ST_OVER, ST_WIN: begin
            if (launch) begin
               mask_d  = '1;
               score_d = '0;
               lives_d = 3'(LIVES);
               state_d = ST_SERVE;
            end
         end
         default: state_d = ST_SERVE;
      endcase
   end

   assign x_out        = x_q;
   assign y_out        = y_q;
   assign erase_enable = erase_q;
   assign e_pos        = epos_q;
   assign active_mask  = mask_q;
   assign score        = score_q;
   assign lives        = lives_q;
   assign game_over    = (state_q == ST_OVER);
   assign win          = (state_q == ST_WIN);
   assign busy         = busy_w;
   assign tick_overrun = ovr_q;

endmodule

// File: tb/tb_ball_engine.sv
// Testbench for ball_engine: directed reset/serve/overrun/mid-scan-reset steps
// plus randomized play checked against a behavioural game model.
module tb_ball_engine;

   localparam int SW = 640, SH = 480, BALL = 7, ROWS = 5, COLS = 5, N = 25;
   localparam int BX0 = 40, BY0 = 40, BW = 80, BH = 30, PTX = 120, PTY = 50;
   localparam int PADY = 440, PADW = 100, PADH = 10, SPEED = 4, LIVES = 3;

   logic          clk, reset, frame_tick, launch;
   logic [9:0]    paddle_x, x_out, y_out;
   logic          erase_enable;
   logic [5:0]    e_pos;
   logic [N-1:0]  active_mask;
   logic [15:0]   score;
   logic [2:0]    lives;
   logic          game_over, win, busy, tick_overrun;

   int checks = 0;
   int errors = 0;

   // behavioural game state
   int            m_x, m_y, m_dx, m_dy, m_score, m_lives, m_hit;
   logic [N-1:0]  m_mask;
   int            games_over = 0;

   ball_engine dut (
      .clk          (clk),
      .reset        (reset),
      .frame_tick   (frame_tick),
      .launch       (launch),
      .paddle_x     (paddle_x),
      .x_out        (x_out),
      .y_out        (y_out),
      .erase_enable (erase_enable),
      .e_pos        (e_pos),
      .active_mask  (active_mask),
      .score        (score),
      .lives        (lives),
      .game_over    (game_over),
      .win          (win),
      .busy         (busy),
      .tick_overrun (tick_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int track_x(input int px);
      return px + PADW / 2 - BALL / 2;
   endfunction

   task automatic model_restart();
      m_mask  = '1;
      m_score = 0;
      m_lives = LIVES;
      m_dx    = 0;
      m_dy    = 0;
   endtask

   // one physics step from the game rules: move, walls, first brick hit, paddle
   // returns 1 = keep playing, 2 = ball lost, 3 = all bricks gone
   task automatic model_step(input int px, output int outcome);
      int nx, ny, cx, bx, by, c, i;
      cx = m_x + BALL / 2;
      nx = m_x + m_dx;
      ny = m_y + m_dy;
      if (nx < 0)            begin nx = 0;         m_dx = -m_dx; end
      else if (nx > SW-BALL) begin nx = SW - BALL; m_dx = -m_dx; end
      if (ny < 0)            begin ny = 0;         m_dy = -m_dy; end
      m_x = nx;
      m_y = ny;
      m_hit = -1;
      for (int r = 0; r < ROWS; r++) begin
         for (int k = 0; k < COLS; k++) begin
            i  = r * COLS + k;
            bx = BX0 + k * PTX;
            by = BY0 + r * PTY;
            if (m_hit < 0 && m_mask[i] && m_x < bx + BW && m_x + BALL > bx &&
                m_y < by + BH && m_y + BALL > by) begin
               m_hit     = i;
               m_mask[i] = 1'b0;
               if (m_score < 65535) m_score++;
               if (cx >= bx && cx < bx + BW) m_dy = -m_dy;
               else                          m_dx = -m_dx;
            end
         end
      end
      if (m_dy > 0 && m_y + BALL >= PADY && m_y < PADY + PADH &&
          m_x < px + PADW && m_x + BALL > px) begin
         m_dy = -SPEED;
         c = m_x + BALL / 2;
         if (c < px + PADW / 3)          m_dx = -SPEED;
         else if (c >= px + 2 * PADW / 3) m_dx = SPEED;
      end
      if (m_y >= SH - BALL)  outcome = 2;
      else if (m_mask == '0) outcome = 3;
      else                   outcome = 1;
   endtask

   // caller guarantees the DUT is in SERVE
   task automatic serve_and_launch(input int px, input bit with_tick);
      @(negedge clk);
      paddle_x = 10'(px);
      @(negedge clk);
      check("serve_x", longint'(x_out), longint'(track_x(px)));
      check("serve_y", longint'(y_out), longint'(PADY - BALL - 1));
      launch     = 1'b1;
      frame_tick = with_tick;
      @(negedge clk);
      launch     = 1'b0;
      frame_tick = 1'b0;
      m_x  = track_x(px);
      m_y  = PADY - BALL - 1;
      m_dx = -SPEED;
      m_dy = -SPEED;
      check("launch_busy", longint'(busy), 0);
   endtask

   task automatic do_step(input bit ovr, input bit with_launch, output int outcome);
      int cyc, pulses, ep, started;
      @(negedge clk);
      frame_tick = 1'b1;
      launch     = with_launch;
      @(negedge clk);
      frame_tick = ovr;
      launch     = 1'b0;
      started = int'(busy);
      cyc = 0;
      pulses = 0;
      ep = -1;
      while (busy === 1'b1 && cyc < N + 3) begin
         if (erase_enable === 1'b1) begin
            pulses++;
            ep = int'(e_pos);
         end
         @(negedge clk);
         frame_tick = 1'b0;
         cyc++;
      end
      model_step(int'(paddle_x), outcome);
      check("step_busy_rise", longint'(started), 1);
      check("step_latency", longint'(busy), 0);
      check("step_x", longint'(x_out), longint'(m_x));
      check("step_y", longint'(y_out), longint'(m_y));
      check("step_mask", longint'(active_mask), longint'(m_mask));
      check("step_score", longint'(score), longint'(m_score));
      check("erase_pulses", longint'(pulses), (m_hit >= 0) ? 1 : 0);
      if (m_hit >= 0) check("e_pos", longint'(ep), longint'(m_hit));
      check("erase_idle", longint'(erase_enable), 0);
      check("win_flag", longint'(win), (outcome == 3) ? 1 : 0);
   endtask

   task automatic restart_from_end();
      launch = 1'b1;
      @(negedge clk);
      launch = 1'b0;
      model_restart();
      check("restart_lives", longint'(lives), longint'(LIVES));
      check("restart_mask", longint'(active_mask), longint'(m_mask));
      check("restart_score", longint'(score), 0);
      check("restart_over", longint'(game_over), 0);
   endtask

   task automatic handle_outcome(input int outcome);
      if (outcome == 2) begin
         @(negedge clk);
         m_lives--;
         check("lost_lives", longint'(lives), longint'(m_lives));
         check("lost_over", longint'(game_over), (m_lives == 0) ? 1 : 0);
         if (m_lives == 0) begin
            games_over++;
            restart_from_end();
         end
         serve_and_launch(int'($urandom_range(0, SW - PADW)), 1'($urandom_range(0, 1)));
      end else if (outcome == 3) begin
         restart_from_end();
         serve_and_launch(int'($urandom_range(0, SW - PADW)), 1'b0);
      end
   endtask

   initial begin
      int oc, px;
      reset      = 1'b0;
      frame_tick = 1'b0;
      launch     = 1'b0;
      paddle_x   = 10'd270;
      repeat (2) @(negedge clk);
      model_restart();
      check("rst_mask", longint'(active_mask), longint'(m_mask));
      check("rst_score", longint'(score), 0);
      check("rst_lives", longint'(lives), longint'(LIVES));
      check("rst_erase", longint'(erase_enable), 0);
      check("rst_epos", longint'(e_pos), 0);
      check("rst_over", longint'(game_over), 0);
      check("rst_win", longint'(win), 0);
      check("rst_ovr", longint'(tick_overrun), 0);
      check("rst_busy", longint'(busy), 0);
      reset = 1'b1;
      @(negedge clk);
      check("first_edge_x", longint'(x_out), longint'(track_x(270)));
      check("first_edge_y", longint'(y_out), longint'(PADY - BALL - 1));

      // first serve and step from paddle 270
      serve_and_launch(270, 1'b0);
      do_step(1'b0, 1'b0, oc);
      handle_outcome(oc);
      check("no_overrun", longint'(tick_overrun), 0);

      // tick during a running step is dropped and flagged
      do_step(1'b1, 1'b0, oc);
      handle_outcome(oc);
      check("overrun_set", longint'(tick_overrun), 1);
      do_step(1'b0, 1'b0, oc);
      handle_outcome(oc);
      check("overrun_held", longint'(tick_overrun), 1);

      // randomized play: paddle often under the ball, sometimes anywhere
      for (int s = 0; s < 1400 && games_over < 2; s++) begin
         if ($urandom_range(0, 1) == 1) px = m_x + 3 - int'($urandom_range(0, 99));
         else                           px = int'($urandom_range(0, SW - PADW));
         if (px < 0)         px = 0;
         if (px > SW - PADW) px = SW - PADW;
         paddle_x = 10'(px);
         do_step(1'b0, 1'($urandom_range(0, 7) == 0), oc);
         handle_outcome(oc);
      end
      check("overrun_sticky", longint'(tick_overrun), 1);

      // reset landing in the middle of a brick scan
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      model_restart();
      check("mid_erase", longint'(erase_enable), 0);
      check("mid_busy", longint'(busy), 0);
      check("mid_mask", longint'(active_mask), longint'(m_mask));
      check("mid_score", longint'(score), 0);
      check("mid_lives", longint'(lives), longint'(LIVES));
      check("mid_epos", longint'(e_pos), 0);
      check("mid_over", longint'(game_over), 0);
      check("mid_win", longint'(win), 0);
      check("mid_ovr", longint'(tick_overrun), 0);
      @(negedge clk);
      reset = 1'b1;
      serve_and_launch(200, 1'b0);
      do_step(1'b0, 1'b0, oc);
      handle_outcome(oc);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
